// File: rtl/load_store_unit_if.sv
// Core-side request/response and DataMemory-side signals of the load/store unit.
// slave = the LSU itself; master = the environment (core plus DataMemory).
interface load_store_unit_if;
  logic        memRd;
  logic        memWr;
  logic [1:0]  size;
  logic        signExt;
  logic [63:0] dir;
  logic [63:0] dataWr;
  logic [63:0] dataRd;
  logic        stall;
  logic        fault;
  logic [63:0] faultDir;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_dir;
  logic [63:0] mem_dataWr;
  logic [63:0] mem_dataRd;

  modport slave (
    input  memRd, memWr, size, signExt, dir, dataWr, mem_dataRd,
    output dataRd, stall, fault, faultDir, mem_rd, mem_wr, mem_dir, mem_dataWr
  );

  modport master (
    output memRd, memWr, size, signExt, dir, dataWr, mem_dataRd,
    input  dataRd, stall, fault, faultDir, mem_rd, mem_wr, mem_dir, mem_dataWr
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word/dword load-store in front of a 64-bit doubleword-indexed memory.
// Sub-dword stores are a two-cycle read-modify-write; misaligned requests set a sticky fault.
module load_store_unit (
  input logic             clk,
  input logic             reset,
  load_store_unit_if.slave bus
);
  typedef enum logic {IDLE, WRITE} state_e;

  state_e      state_q, state_d;
  logic [63:0] merge_q, merge_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] fault_dir_q, fault_dir_d;
  logic        fault_q, fault_d;

  logic [2:0]  off;
  logic [5:0]  sh;
  logic        aligned, illegal;
  logic [7:0]  byte_mask, bm_sh;
  logic [63:0] lanes, rd_ext, lane_mask, wr_shift;
  logic        rd_c, wr_c, stall_c;
  logic [63:0] data_rd_c, mem_dir_c, mem_wdata_c;

  assign off      = bus.dir[2:0];
  assign sh       = {off, 3'b000};
  assign lanes    = bus.mem_dataRd >> sh;
  assign wr_shift = bus.dataWr << sh;
  assign bm_sh    = 8'(byte_mask << off);

  always_comb begin
    aligned   = 1'b1;
    byte_mask = 8'hFF;
    rd_ext    = lanes;
    case (bus.size)
      2'b00: begin
        byte_mask = 8'h01;
        rd_ext    = {{56{bus.signExt & lanes[7]}}, lanes[7:0]};
      end
      2'b01: begin
        aligned   = ~off[0];
        byte_mask = 8'h03;
        rd_ext    = {{48{bus.signExt & lanes[15]}}, lanes[15:0]};
      end
      2'b10: begin
        aligned   = (off[1:0] == 2'b00);
        byte_mask = 8'h0F;
        rd_ext    = {{32{bus.signExt & lanes[31]}}, lanes[31:0]};
      end
      default: begin
        aligned   = (off == 3'b000);
        byte_mask = 8'hFF;
        rd_ext    = lanes;
      end
    endcase
  end

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < 8; k++) lane_mask[k*8 +: 8] = {8{bm_sh[k]}};
  end

  assign illegal = (bus.memRd & bus.memWr) | ((bus.memRd | bus.memWr) & ~aligned);

  always_comb begin
    state_d     = state_q;
    merge_d     = merge_q;
    addr_d      = addr_q;
    fault_d     = fault_q;
    fault_dir_d = fault_dir_q;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    stall_c     = 1'b0;
    data_rd_c   = '0;
    mem_wdata_c = '0;
    mem_dir_c   = {3'b000, bus.dir[63:3]};
    case (state_q)
      IDLE: begin
        if (illegal) begin
          fault_d = 1'b1;
          if (!fault_q) fault_dir_d = bus.dir;
        end else if (bus.memRd) begin
          rd_c      = 1'b1;
          data_rd_c = rd_ext;
        end else if (bus.memWr) begin
          if (bus.size == 2'b11) begin
            wr_c        = 1'b1;
            mem_wdata_c = bus.dataWr;
          end else begin
            // read phase of the RMW: splice the new lanes into the current dword
            rd_c    = 1'b1;
            stall_c = 1'b1;
            merge_d = (bus.mem_dataRd & ~lane_mask) | (wr_shift & lane_mask);
            addr_d  = {3'b000, bus.dir[63:3]};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        mem_dir_c   = addr_q;
        wr_c        = 1'b1;
        mem_wdata_c = merge_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // reset masks strobes immediately so a reset in WRITE drops the partial store
  assign bus.mem_rd     = rd_c & ~reset;
  assign bus.mem_wr     = wr_c & ~reset;
  assign bus.stall      = stall_c & ~reset;
  assign bus.dataRd     = reset ? 64'h0 : data_rd_c;
  assign bus.mem_dir    = mem_dir_c;
  assign bus.mem_dataWr = mem_wdata_c;
  assign bus.fault      = fault_q;
  assign bus.faultDir   = fault_dir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      merge_q     <= '0;
      addr_q      <= '0;
      fault_q     <= 1'b0;
      fault_dir_q <= '0;
    end else begin
      state_q     <= state_d;
      merge_q     <= merge_d;
      addr_q      <= addr_d;
      fault_q     <= fault_d;
      fault_dir_q <= fault_dir_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-dword combinational-read memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;

  load_store_unit_if bus();
  load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [63:0] mem [0:15] = '{default: 64'h0};
  assign bus.mem_dataRd = mem[bus.mem_dir[3:0]];
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_dir[3:0]] <= bus.mem_dataWr;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                     input logic [63:0] a, input logic [63:0] d);
    bus.memRd   = rd;
    bus.memWr   = wr;
    bus.size    = sz;
    bus.signExt = sx;
    bus.dir     = a;
    bus.dataWr  = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ld_chk(input string tag, input logic [1:0] sz, input logic sx,
                        input logic [63:0] a, input logic [63:0] exp);
    req(1'b1, 1'b0, sz, sx, a, 64'h0);
    @(negedge clk);
    chk(tag, bus.dataRd, exp);
    tick();
  endtask

  task automatic dw_store(input logic [63:0] a, input logic [63:0] d);
    req(1'b0, 1'b1, 2'b11, 1'b0, a, d);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req(1'b1, 1'b0, 2'b11, 1'b0, 64'h0, 64'h0);
    tick();
    @(negedge clk);
    chk("rst_mem_rd", bus.mem_rd, 1'b0);
    chk("rst_mem_wr", bus.mem_wr, 1'b0);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_dataRd", bus.dataRd, 64'h0);
    chk("rst_fault", bus.fault, 1'b0);
    chk("rst_faultDir", bus.faultDir, 64'h0);
    tick();
    reset = 1'b0;

    // dword store then load
    req(1'b0, 1'b1, 2'b11, 1'b0, 64'd8, 64'h1122334455667788);
    @(negedge clk);
    chk("dw_st_wr", bus.mem_wr, 1'b1);
    chk("dw_st_dir", bus.mem_dir, 64'd1);
    chk("dw_st_data", bus.mem_dataWr, 64'h1122334455667788);
    chk("dw_st_stall", bus.stall, 1'b0);
    tick();
    req(1'b1, 1'b0, 2'b11, 1'b0, 64'd8, 64'h0);
    @(negedge clk);
    chk("dw_ld_data", bus.dataRd, 64'h1122334455667788);
    chk("dw_ld_rd", bus.mem_rd, 1'b1);
    chk("dw_ld_stall", bus.stall, 1'b0);
    tick();

    // byte RMW into mem[1], upper dataWr bits must be ignored
    req(1'b0, 1'b1, 2'b00, 1'b0, 64'd11, 64'hFFFFFFFF123456AB);
    @(negedge clk);
    chk("rmw_c1_stall", bus.stall, 1'b1);
    chk("rmw_c1_rd", bus.mem_rd, 1'b1);
    chk("rmw_c1_wr", bus.mem_wr, 1'b0);
    chk("rmw_c1_dir", bus.mem_dir, 64'd1);
    tick();
    @(negedge clk);
    chk("rmw_c2_wr", bus.mem_wr, 1'b1);
    chk("rmw_c2_rd", bus.mem_rd, 1'b0);
    chk("rmw_c2_stall", bus.stall, 1'b0);
    chk("rmw_c2_dir", bus.mem_dir, 64'd1);
    chk("rmw_c2_data", bus.mem_dataWr, 64'h11223344AB667788);
    tick();
    req(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    chk("idle_dataWr", bus.mem_dataWr, 64'h0);
    chk("idle_rd", bus.mem_rd, 1'b0);
    chk("rmw_mem1", mem[1], 64'h11223344AB667788);
    tick();

    // sign / zero extension
    dw_store(64'd0, 64'h000000008000F0FF);
    ld_chk("ldb_s", 2'b00, 1'b1, 64'd0, 64'hFFFFFFFFFFFFFFFF);
    ld_chk("ldb_z", 2'b00, 1'b0, 64'd0, 64'h00000000000000FF);
    ld_chk("ldsw", 2'b10, 1'b1, 64'd0, 64'hFFFFFFFF8000F0FF);
    ld_chk("ldw_z", 2'b10, 1'b0, 64'd0, 64'h000000008000F0FF);
    ld_chk("ldh2_s", 2'b01, 1'b1, 64'd2, 64'hFFFFFFFFFFFF8000);
    ld_chk("ldh2_z", 2'b01, 1'b0, 64'd2, 64'h0000000000008000);
    ld_chk("ldh0_s", 2'b01, 1'b1, 64'd0, 64'hFFFFFFFFFFFFF0FF);
    ld_chk("ldb1_s", 2'b00, 1'b1, 64'd1, 64'hFFFFFFFFFFFFFFF0);
    ld_chk("ldb3_s", 2'b00, 1'b1, 64'd3, 64'hFFFFFFFFFFFFFF80);
    ld_chk("ldb3_z", 2'b00, 1'b0, 64'd3, 64'h0000000000000080);
    ld_chk("ldw4_s", 2'b10, 1'b1, 64'd4, 64'h0000000000000000);

    // misaligned half store
    req(1'b0, 1'b1, 2'b01, 1'b0, 64'h13, 64'hBEEF);
    @(negedge clk);
    chk("mis_rd", bus.mem_rd, 1'b0);
    chk("mis_wr", bus.mem_wr, 1'b0);
    chk("mis_stall", bus.stall, 1'b0);
    chk("mis_fault_pre", bus.fault, 1'b0);
    tick();
    req(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    chk("mis_fault", bus.fault, 1'b1);
    chk("mis_faultDir", bus.faultDir, 64'h13);
    chk("mis_mem2", mem[2], 64'h0);
    tick();
    req(1'b1, 1'b0, 2'b10, 1'b1, 64'h21, 64'h0);
    @(negedge clk);
    chk("mis2_rd", bus.mem_rd, 1'b0);
    chk("mis2_dataRd", bus.dataRd, 64'h0);
    tick();
    req(1'b1, 1'b1, 2'b11, 1'b0, 64'd8, 64'h0);
    @(negedge clk);
    chk("mis2_fault", bus.fault, 1'b1);
    chk("mis2_faultDir", bus.faultDir, 64'h13);
    chk("both_rd", bus.mem_rd, 1'b0);
    chk("both_wr", bus.mem_wr, 1'b0);
    chk("both_dataRd", bus.dataRd, 64'h0);
    tick();
    req(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    chk("both_mem1", mem[1], 64'h11223344AB667788);
    tick();

    // reset during the WRITE cycle of STURH dir=2
    dw_store(64'd0, 64'h0123456789ABCDEF);
    req(1'b0, 1'b1, 2'b01, 1'b0, 64'd2, 64'hBEEF);
    @(negedge clk);
    chk("rr_c1_stall", bus.stall, 1'b1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rr_c2_wr", bus.mem_wr, 1'b0);
    tick();
    reset = 1'b0;
    req(1'b1, 1'b0, 2'b11, 1'b0, 64'd0, 64'h0);
    @(negedge clk);
    chk("rr_mem0", mem[0], 64'h0123456789ABCDEF);
    chk("rr_fault", bus.fault, 1'b0);
    chk("rr_faultDir", bus.faultDir, 64'h0);
    chk("rr_idle_wr", bus.mem_wr, 1'b0);
    chk("rr_idle_rd", bus.mem_rd, 1'b1);
    chk("rr_idle_ld", bus.dataRd, 64'h0123456789ABCDEF);
    tick();

    // back-to-back byte stores into the same dword
    dw_store(64'd0, 64'h0);
    req(1'b0, 1'b1, 2'b00, 1'b0, 64'd0, 64'h01);
    @(negedge clk);
    chk("bb_c1_stall", bus.stall, 1'b1);
    tick();
    @(negedge clk);
    chk("bb_c2_wr", bus.mem_wr, 1'b1);
    chk("bb_c2_data", bus.mem_dataWr, 64'h01);
    tick();
    req(1'b0, 1'b1, 2'b00, 1'b0, 64'd1, 64'h02);
    @(negedge clk);
    chk("bb_c3_stall", bus.stall, 1'b1);
    chk("bb_c3_rd", bus.mem_rd, 1'b1);
    tick();
    @(negedge clk);
    chk("bb_c4_stall", bus.stall, 1'b0);
    chk("bb_c4_data", bus.mem_dataWr, 64'h0201);
    tick();
    req(1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    chk("bb_mem0", mem[0], 64'h0201);
    chk("bb_idle_stall", bus.stall, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core's execute stage and `DataMemory`. `DataMemory` is 64-bit wide, doubleword-indexed, with combinational read. This block adds byte, halfword and word accesses (LDURB/LDURH/LDURSW/STURB/STURH/STURW), little-endian lane extraction, sign-extension, alignment checking and a two-cycle read-modify-write for sub-doubleword stores, stalling the core meanwhile. Doubleword accesses and all loads complete in one cycle.

## Interface
- No parameters; data and address paths fixed at 64 bits.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `memRd` in 1: load request from core.
- `memWr` in 1: store request from core.
- `size` in 2: 00 byte, 01 half, 10 word, 11 doubleword.
- `signExt` in 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `dir` in 64: byte address.
- `dataWr` in 64: store data; valid bits are the low 8/16/32/64 per `size`.
- `dataRd` out 64: extracted, extended load data (combinational).
- `stall` out 1: core must hold PC and all request inputs this cycle.
- `fault` out 1: sticky error flag, registered.
- `faultDir` out 64: `dir` of the first faulting request, registered.
- `mem_rd`, `mem_wr` out 1: to `DataMemory` `memRd`/`memWr`.
- `mem_dir` out 64: doubleword index, to `DataMemory` `dir`.
- `mem_dataWr` out 64: to `DataMemory` `dataWr`.
- `mem_dataRd` in 64: from `DataMemory` `dataRd`.

## Operation
- `off` = `dir[2:0]`. Lane k = bits [8k+7:8k]. `mem_dir` = `dir >> 3` in IDLE, `addr_q` in WRITE.
- Aligned: byte always; half needs `dir[0]`=0; word needs `dir[1:0]`=0; dword needs `dir[2:0]`=0.
- Illegal request: misaligned, or `memRd` and `memWr` both 1.
  - No memory access.
  - `dataRd`=0.
  - On the next edge: `fault`←1. If `fault` was 0, `faultDir`←`dir`.
  - Later faults leave `faultDir` unchanged.
- FSM states: IDLE, WRITE.
- IDLE, load:
  - `mem_rd`=1.
  - `dataRd` = selected lanes (byte at `off`, half at `off[2:1]`, word at `off[2]`, or all 64 bits), extended per `signExt`.
  - `stall`=0. Stays in IDLE.
- IDLE, dword store: `mem_wr`=1, `mem_dataWr`=`dataWr`, `stall`=0. Stays in IDLE.
- IDLE, sub-dword store (aligned):
  - `mem_rd`=1, `stall`=1.
  - On the edge: `merge_q` ← `mem_dataRd` with the target lanes replaced by the low bytes of `dataWr`; `addr_q` ← `dir >> 3`; go to WRITE.
- WRITE:
  - `mem_wr`=1, `mem_dataWr`=`merge_q`, `mem_rd`=0, `stall`=0.
  - Core request inputs are ignored; these are the held values of the same store.
  - Always returns to IDLE.
- No request: all memory strobes 0, `dataRd`=0, `mem_dataWr`=0.

## Timing
- Reset values:
  - state IDLE.
  - `fault`=0, `faultDir`=0, `merge_q`=0, `addr_q`=0.
  - `stall`=0, `mem_rd`=0, `mem_wr`=0, `dataRd`=0.
- `mem_rd` and `mem_wr` are gated by `!reset` in the same cycle.
  - Reset during WRITE drops the partial store; memory is unmodified.
  - Next state is IDLE.
- Load latency 0 cycles: `dataRd` is valid in the request cycle.
- Dword store: 1 cycle. Sub-dword store: 2 cycles with `stall`=1 in the first only.
- Back-to-back sub-dword stores: IDLE→WRITE→IDLE→WRITE. Memory write of store N precedes the read of store N+1, so RMW to the same doubleword is coherent.
- `fault` and `faultDir` are cleared only by `reset`.

## Test plan
- Dword store then load: store `dir`=8, `dataWr`=0x1122334455667788, `size`=11; then load `dir`=8, `size`=11 → `dataRd`=0x1122334455667788; `stall` never 1.
- Byte RMW: `mem[1]`=0x1122334455667788; STURB `dir`=11, `dataWr`=0xAB → cycle 1 `stall`=1, `mem_rd`=1, `mem_dir`=1; cycle 2 `mem_wr`=1, `mem_dataWr`=0x11223344AB667788.
- Sign/zero extension: `mem[0]`=0x00000000_8000F0FF.
  - LDURB `dir`=0, `signExt`=1 → 0xFFFFFFFFFFFFFFFF.
  - Same with `signExt`=0 → 0xFF.
  - LDURSW `dir`=0 → 0xFFFFFFFF8000F0FF.
- Misaligned: half store `dir`=0x13 → no strobes; next cycle `fault`=1, `faultDir`=0x13. A second fault at `dir`=0x21 leaves `faultDir`=0x13.
- Reset mid-RMW: assert `reset` in the WRITE cycle of STURH `dir`=2 → `mem_wr`=0, memory unchanged, state IDLE, `fault`=0.
- Back-to-back STURB `dir`=0 (0x01) and `dir`=1 (0x02) into `mem[0]`=0 → final `mem[0]`=0x0201; four cycles total.
